// File: rtl/vga_timing_detector.sv
// Receive-side video timing detector.
// Recovers pixel position and start-of-frame from raw hsync/vsync/de,
// measures frame geometry and reports lock once consecutive frames agree.
// Optional statistics ports are enabled by defining VGA_TIMING_DETECTOR_STATS_EN.
module vga_timing_detector #(
    parameter int unsigned XY_BITW     = 16,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               de,
    output logic               de_o,
    output logic [XY_BITW-1:0] sx,
    output logic [XY_BITW-1:0] sy,
    output logic               frame,
    output logic [XY_BITW-1:0] h_total,
    output logic [XY_BITW-1:0] h_active,
    output logic [XY_BITW-1:0] v_total,
    output logic [XY_BITW-1:0] v_active,
    output logic               locked,
    output logic               err
`ifdef VGA_TIMING_DETECTOR_STATS_EN
    ,
    output logic [31:0]        frame_count,
    output logic [15:0]        err_count
`endif
);

    localparam logic [XY_BITW-1:0] MaxVal  = '1;
    localparam logic [XY_BITW-1:0] One     = XY_BITW'(1);
    localparam logic [31:0]        LockTgt = 32'(LOCK_FRAMES - 1);
    localparam int unsigned        CandW   = 4 * XY_BITW;

    typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

    // Input pipeline: s1 is the registered input, s2 the previous s1.
    logic hs1_q, vs1_q, de1_q;
    logic hs2_q, vs2_q, de2_q;
    logic hs_edge, vs_edge, de_rise, de_fall;

    // Position recovery.
    logic               de_o_q, frame_q, new_frame_q;
    logic [XY_BITW-1:0] sx_q, sy_q;

    // Working measurement counters.
    logic [XY_BITW-1:0] hcnt_q, hcnt_d;
    logic [XY_BITW-1:0] acnt_q, acnt_d;
    logic [XY_BITW-1:0] lcnt_q, lcnt_d;
    logic [XY_BITW-1:0] rcnt_q, rcnt_d;
    logic [XY_BITW-1:0] line_len_q, line_len_d;
    logic [XY_BITW-1:0] line_active_q, line_active_d;
    logic [XY_BITW-1:0] cand_lcnt;

    // Candidate and committed geometry, packed {h_total, h_active, v_total, v_active}.
    logic [CandW-1:0] cand, stored_q;
    logic             cand_match, hsat, line_bad, run_bad;

    state_e      state_q;
    logic [31:0] match_cnt_q, match_next;
    logic        locked_q, err_q;

    function automatic logic [XY_BITW-1:0] sat_inc(input logic [XY_BITW-1:0] v);
        return (v == MaxVal) ? v : v + One;
    endfunction

    // Register raw inputs twice; reset to inactive levels so no edge follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs1_q <= ~HS_POL;
            vs1_q <= ~VS_POL;
            de1_q <= 1'b0;
            hs2_q <= ~HS_POL;
            vs2_q <= ~VS_POL;
            de2_q <= 1'b0;
        end else begin
            hs1_q <= hsync;
            vs1_q <= vsync;
            de1_q <= de;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            de2_q <= de1_q;
        end
    end

    assign hs_edge = (hs1_q == HS_POL) && (hs2_q != HS_POL);
    assign vs_edge = (vs1_q == VS_POL) && (vs2_q != VS_POL);
    assign de_rise = de1_q && !de2_q;
    assign de_fall = !de1_q && de2_q;

    // Next-state of the measurement counters and the frame candidate.
    always_comb begin
        hcnt_d        = hs_edge ? '0 : sat_inc(hcnt_q);
        line_len_d    = hs_edge ? sat_inc(hcnt_q) : line_len_q;
        acnt_d        = acnt_q;
        if (de_rise) begin
            acnt_d = One;
        end else if (de1_q) begin
            acnt_d = sat_inc(acnt_q);
        end
        line_active_d = de_fall ? acnt_q : line_active_q;
        // A line ending on the vsync edge belongs to the frame being committed.
        cand_lcnt     = hs_edge ? sat_inc(lcnt_q) : lcnt_q;
        lcnt_d        = vs_edge ? '0 : cand_lcnt;
        // A de run starting on the vsync edge belongs to the new frame.
        rcnt_d        = vs_edge ? '0 : rcnt_q;
        if (de_rise) begin
            rcnt_d = vs_edge ? One : sat_inc(rcnt_q);
        end
        cand       = {line_len_d, line_active_d, cand_lcnt, rcnt_q};
        cand_match = (cand == stored_q);
        match_next = cand_match ? match_cnt_q + 32'd1 : 32'd0;
        hsat       = (hcnt_q == MaxVal);
        line_bad   = hs_edge && (line_len_d != stored_q[CandW-1 -: XY_BITW]);
        run_bad    = de_fall && (acnt_q != stored_q[3*XY_BITW-1 -: XY_BITW]);
    end

    // Measurement counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q        <= '0;
            acnt_q        <= '0;
            lcnt_q        <= '0;
            rcnt_q        <= '0;
            line_len_q    <= '0;
            line_active_q <= '0;
        end else begin
            hcnt_q        <= hcnt_d;
            acnt_q        <= acnt_d;
            lcnt_q        <= lcnt_d;
            rcnt_q        <= rcnt_d;
            line_len_q    <= line_len_d;
            line_active_q <= line_active_d;
        end
    end

    // Pixel position, aligned de and start-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_o_q      <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
            frame_q     <= 1'b0;
            new_frame_q <= 1'b0;
        end else begin
            de_o_q  <= de1_q;
            frame_q <= 1'b0;
            if (vs_edge) begin
                new_frame_q <= 1'b1;
            end
            if (de_rise) begin
                sx_q <= '0;
                if (new_frame_q || vs_edge) begin
                    sy_q        <= '0;
                    new_frame_q <= 1'b0;
                    frame_q     <= 1'b1;
                end else begin
                    sy_q <= sat_inc(sy_q);
                end
            end else if (de1_q) begin
                sx_q <= sat_inc(sx_q);
            end
        end
    end

    // Lock state machine with committed geometry, lock flag and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSearch;
            match_cnt_q <= '0;
            stored_q    <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (hsat) begin
                // No hsync for a full counter range: the source is gone.
                state_q     <= StSearch;
                match_cnt_q <= '0;
                locked_q    <= 1'b0;
                err_q       <= (state_q == StLocked);
            end else begin
                unique case (state_q)
                    StSearch: begin
                        if (vs_edge) begin
                            state_q     <= StMeasure;
                            match_cnt_q <= '0;
                        end
                    end
                    StMeasure: begin
                        if (vs_edge) begin
                            stored_q    <= cand;
                            match_cnt_q <= match_next;
                            if (match_next >= LockTgt) begin
                                state_q  <= StLocked;
                                locked_q <= 1'b1;
                            end
                        end
                    end
                    StLocked: begin
                        if (line_bad || run_bad || (vs_edge && !cand_match)) begin
                            state_q     <= StMeasure;
                            match_cnt_q <= '0;
                            locked_q    <= 1'b0;
                            err_q       <= 1'b1;
                            stored_q    <= cand;
                        end else if (vs_edge) begin
                            stored_q <= cand;
                        end
                    end
                    default: state_q <= StSearch;
                endcase
            end
        end
    end

`ifdef VGA_TIMING_DETECTOR_STATS_EN
    logic [31:0] frame_count_q;
    logic [15:0] err_count_q;

    // Frame commits while locked, and saturating count of error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            if (vs_edge && !hsat && (state_q == StLocked)) begin
                frame_count_q <= frame_count_q + 32'd1;
            end
            if (err_q && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
`endif

    assign de_o     = de_o_q;
    assign sx       = sx_q;
    assign sy       = sy_q;
    assign frame    = frame_q;
    assign h_total  = stored_q[CandW-1 -: XY_BITW];
    assign h_active = stored_q[3*XY_BITW-1 -: XY_BITW];
    assign v_total  = stored_q[2*XY_BITW-1 -: XY_BITW];
    assign v_active = stored_q[XY_BITW-1 -: XY_BITW];
    assign locked   = locked_q;
    assign err      = err_q;

endmodule

// File: tb/tb_vga_timing_detector.sv
// Scoreboard bench for vga_timing_detector on a small video format.
// Expected outputs are queued per driven pixel and compared two clocks later.
module tb_vga_timing_detector;

    localparam int unsigned XY_BITW     = 10;
    localparam bit          HS_POL      = 1'b0;
    localparam bit          VS_POL      = 1'b0;
    localparam int          LOCK_FRAMES = 2;

    // Line: active, front porch, sync, back porch. Frame likewise in lines.
    localparam int H_ACT = 8;
    localparam int H_FP = 2;
    localparam int H_SYNC = 3;
    localparam int H_BP = 3;
    localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_ACT = 5;
    localparam int V_FP = 1;
    localparam int V_SYNC = 2;
    localparam int V_BP = 2;
    localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HS0 = H_ACT + H_FP;
    localparam int VS0 = V_ACT + V_FP;
    localparam int VS1 = VS0 + V_SYNC;

    logic               clk = 1'b0;
    logic               rst;
    logic               hsync, vsync, de;
    logic               de_o, frame, locked, err;
    logic [XY_BITW-1:0] sx, sy, h_total, h_active, v_total, v_active;
`ifdef VGA_TIMING_DETECTOR_STATS_EN
    logic [31:0]        frame_count;
    logic [15:0]        err_count;
`endif

    vga_timing_detector #(
        .XY_BITW    (XY_BITW),
        .HS_POL     (HS_POL),
        .VS_POL     (VS_POL),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .de_o       (de_o),
        .sx         (sx),
        .sy         (sy),
        .frame      (frame),
        .h_total    (h_total),
        .h_active   (h_active),
        .v_total    (v_total),
        .v_active   (v_active),
        .locked     (locked),
        .err        (err)
`ifdef VGA_TIMING_DETECTOR_STATS_EN
        ,
        .frame_count(frame_count),
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       de;
        logic [9:0] sx;
        logic [9:0] sy;
        logic       frame;
        bit         chk_pos;
        bit         chk_lock;
        logic       locked;
        logic       err;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_errs = 0;

    // Generator-side tracking of what the stream should have produced.
    bit prev_vs;
    bit synced;
    bit exp_locked;
    int edges_to_lock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        hsync = ~HS_POL;
        vsync = ~VS_POL;
        de    = 1'b0;
    endtask

    // One clock: compare the output due now, then drive the next input and queue its result.
    task automatic step(input bit hs_a, input bit vs_a, input bit de_a, input exp_t e);
        exp_t c;
        @(posedge clk);
        #1;
        if (q.size() == 2) begin
            c = q.pop_front();
            check_eq("de_o", de_o, c.de);
            check_eq("frame", frame, c.frame);
            if (c.chk_pos && c.de) begin
                check_eq("sx", sx, c.sx);
                check_eq("sy", sy, c.sy);
            end
            if (c.chk_lock) begin
                check_eq("locked", locked, c.locked);
                check_eq("err", err, c.err);
            end
        end
        hsync = hs_a ? HS_POL : ~HS_POL;
        vsync = vs_a ? VS_POL : ~VS_POL;
        de    = de_a;
        q.push_back(e);
    endtask

    task automatic drive_pixel(input int x, input int y, input int err_y);
        bit   hs_a, vs_a, de_a;
        exp_t e;
        hs_a = (x >= HS0) && (x < HS0 + H_SYNC);
        vs_a = ((y > VS0) || (y == VS0 && x >= HS0)) && ((y < VS1) || (y == VS1 && x < HS0));
        de_a = (x < H_ACT) && (y < V_ACT);
        if (vs_a && !prev_vs) begin
            synced = 1'b1;
            if (edges_to_lock > 0) begin
                edges_to_lock--;
                if (edges_to_lock == 0) exp_locked = 1'b1;
            end
        end
        prev_vs = vs_a;
        e.err = 1'b0;
        if (y == err_y && x == HS0) begin
            // The line after the short one ends one clock early.
            e.err         = 1'b1;
            exp_locked    = 1'b0;
            edges_to_lock = LOCK_FRAMES;
        end
        e.de       = de_a;
        e.sx       = 10'(x);
        e.sy       = 10'(y);
        e.frame    = (x == 0) && (y == 0) && synced;
        e.chk_pos  = synced;
        e.chk_lock = 1'b1;
        e.locked   = exp_locked;
        step(hs_a, vs_a, de_a, e);
    endtask

    // Drive one frame; short_y loses a back-porch clock; stop_y/stop_x abort early.
    task automatic drive_frame(input int short_y, input int stop_y, input int stop_x);
        for (int y = 0; y < V_TOTAL; y++) begin
            int len;
            len = (y == short_y) ? H_TOTAL - 1 : H_TOTAL;
            for (int x = 0; x < len; x++) begin
                if (y == stop_y && x == stop_x) return;
                drive_pixel(x, y, (short_y >= 0) ? short_y + 1 : -1);
            end
        end
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        check_eq({tag, "_de_o"}, de_o, 0);
        check_eq({tag, "_sx"}, sx, 0);
        check_eq({tag, "_sy"}, sy, 0);
        check_eq({tag, "_frame"}, frame, 0);
        check_eq({tag, "_h_total"}, h_total, 0);
        check_eq({tag, "_h_active"}, h_active, 0);
        check_eq({tag, "_v_total"}, v_total, 0);
        check_eq({tag, "_v_active"}, v_active, 0);
        check_eq({tag, "_locked"}, locked, 0);
        check_eq({tag, "_err"}, err, 0);
        rst = 1'b0;
        drive_idle();
        prev_vs       = 1'b0;
        synced        = 1'b0;
        exp_locked    = 1'b0;
        edges_to_lock = LOCK_FRAMES + 1;
    endtask

    task automatic check_geom(input string tag);
        check_eq({tag, "_h_total"}, h_total, H_TOTAL);
        check_eq({tag, "_h_active"}, h_active, H_ACT);
        check_eq({tag, "_v_total"}, v_total, V_TOTAL);
        check_eq({tag, "_v_active"}, v_active, V_ACT);
        check_eq({tag, "_locked"}, locked, 1);
    endtask

    initial begin
        int   err_seen;
        exp_t idle_e;
        rst = 1'b1;
        drive_idle();
        apply_reset("reset");

        // Acquire: lock on the third vsync edge, then clean locked frames.
        for (int f = 0; f < 5; f++) begin
            drive_frame(-1, -1, -1);
            if (f == 3) check_geom("acquire");
        end
`ifdef VGA_TIMING_DETECTOR_STATS_EN
        check_eq("frame_count", frame_count, 2);
        check_eq("err_count_clean", err_count, 0);
`endif

        // One short line while locked, then relock.
        drive_frame(1, -1, -1);
        drive_frame(-1, -1, -1);
        drive_frame(-1, -1, -1);
        check_geom("relock");
`ifdef VGA_TIMING_DETECTOR_STATS_EN
        check_eq("err_count_short", err_count, 1);
`endif

        // Reset in the middle of an active line, then reacquire.
        drive_frame(-1, 3, 4);
        apply_reset("midrst");
        for (int f = 0; f < 3; f++) drive_frame(-1, -1, -1);
        check_geom("reacquire");

        // Hsync disappears for longer than the counter range.
        idle_e.de       = 1'b0;
        idle_e.sx       = '0;
        idle_e.sy       = '0;
        idle_e.frame    = 1'b0;
        idle_e.chk_pos  = 1'b0;
        idle_e.chk_lock = 1'b0;
        idle_e.locked   = 1'b0;
        idle_e.err      = 1'b0;
        err_seen = 0;
        for (int i = 0; i < (1 << XY_BITW) + 80; i++) begin
            step(1'b0, 1'b0, 1'b0, idle_e);
            if (err === 1'b1) err_seen++;
        end
        check_eq("sat_err_pulses", err_seen, 1);
        check_eq("sat_locked", locked, 0);
`ifdef VGA_TIMING_DETECTOR_STATS_EN
        check_eq("err_count_sat", err_count, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
